// File: rtl/regfile_wb.sv
// Purpose : 8x16 write-back register file, R0 hardwired to zero, with per-register pending scoreboard.
// Latency : read data and rd_valid 1 cycle after rd_en; a write is readable by a read issued the next cycle.
// Backpress: none; accepts one write, one dual-port read and one issue every cycle, never stalls.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data    write-back port (fed by the write-back mux)
//   rd_en, ra_addr, rb_addr    operand read request
//   ra_data, rb_data, rd_valid registered operand read results
//   iss_en, iss_addr           issue port; marks the destination pending
//   ra_pend, rb_pend, pend_any combinational scoreboard view (pre-edge state)
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to a read
// of the same address. Without it the read returns the previously stored value.

module regfile_wb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             rd_valid,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic             ra_pend,
    output logic             rb_pend,
    output logic             pend_any
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [WIDTH-1:0] ra_rd;
    logic [WIDTH-1:0] rb_rd;
    logic             wr_live;

    // A write to R0 is discarded entirely, so it also never forwards.
    assign wr_live = wr_en && (wr_addr != '0);

    // Read mux. R0 is forced to zero rather than relying on the stored entry.
    always_comb begin
        ra_rd = (ra_addr == '0) ? '0 : mem[ra_addr];
        rb_rd = (rb_addr == '0) ? '0 : mem[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_addr == ra_addr)) ra_rd = wr_data;
        if (wr_live && (wr_addr == rb_addr)) rb_rd = wr_data;
`endif
    end

    // Scoreboard next state: the write-back clears first, then a new issue
    // sets, so an issue colliding with a retiring write keeps the bit set
    // (the new producer is still outstanding).
    always_comb begin
        pend_nxt = pend;
        if (wr_en)  pend_nxt[wr_addr]  = 1'b0;
        if (iss_en) pend_nxt[iss_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend     <= '0;
            ra_data  <= '0;
            rb_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_live) mem[wr_addr] <= wr_data;
            pend <= pend_nxt;
            if (rd_en) begin
                ra_data <= ra_rd;
                rb_data <= rb_rd;
            end
            rd_valid <= rd_en;
        end
    end

    assign ra_pend  = pend[ra_addr];
    assign rb_pend  = pend[rb_addr];
    assign pend_any = |pend;

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Eight-entry, 16-bit register file forming the write-back stage of the datapath: it consumes the 16-bit result selected by the upstream 2:1 write-back multiplexer and supplies two registered operand reads to the execute stage. A per-register pending scoreboard tracks destinations issued but not yet written back, so the issue logic can stall on hazards. R0 is hardwired to zero.

## Interface

Parameters:
- WIDTH, 16, data width; matches the write-back multiplexer output.
- DEPTH, 8, number of registers.
- AW, 3, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write-back strobe.
- wr_addr  input  AW  write-back destination.
- wr_data  input  WIDTH  write-back value (write-back multiplexer output).
- rd_en  input  1  operand read strobe.
- ra_addr  input  AW  port A read address.
- rb_addr  input  AW  port B read address.
- ra_data  output  WIDTH  port A registered read data.
- rb_data  output  WIDTH  port B registered read data.
- rd_valid  output  1  high the cycle after an accepted read.
- iss_en  input  1  instruction issued; marks destination pending.
- iss_addr  input  AW  issued instruction's destination.
- ra_pend  output  1  combinational: pending bit of ra_addr.
- rb_pend  output  1  combinational: pending bit of rb_addr.
- pend_any  output  1  OR of all pending bits.

## Operation

- Storage: DEPTH × WIDTH registers; entry 0 reads as 0 always, writes to address 0 discarded, pending bit 0 never sets.
- Write: wr_en=1 and wr_addr≠0 → mem[wr_addr] ← wr_data at the edge; clears pend[wr_addr].
- Read: rd_en=1 → ra_data ← mem[ra_addr], rb_data ← mem[rb_addr] at the edge; rd_valid ← 1. rd_en=0 → ra_data/rb_data hold previous values, rd_valid ← 0.
- Same-cycle read and write to same non-zero address: behaviour set by REGFILE_BYPASS_EN (see Configuration).
- Scoreboard: iss_en=1 and iss_addr≠0 → pend[iss_addr] ← 1.
- Simultaneous iss_en and wr_en to same address: set wins (pend stays 1; the write retires an older producer, the new issue is still outstanding). Data is still written.
- Simultaneous iss_en and wr_en to different addresses: both take effect.
- Write to a non-pending register is legal; pending bit stays 0.
- ra_pend/rb_pend reflect current registered pend state (pre-edge), no bypass.
- Out-of-range addresses impossible (AW = clog2(DEPTH)); no check.

## Timing

- Reset (rst=1 at edge): all mem entries ← 0, all pend ← 0, ra_data=0, rb_data=0, rd_valid=0. Reset overrides wr_en, rd_en, iss_en in the same cycle.
- Reset mid-operation: any write/issue presented in the reset cycle is lost; first cycle after rst deasserts behaves as fresh.
- Write latency: value visible to a read issued the next cycle (read data appears one cycle after that).
- Read latency: 1 cycle from rd_en to ra_data/rb_data/rd_valid.
- Scoreboard latency: pend set/clear visible on ra_pend/rb_pend/pend_any in the cycle after the edge.
- Throughput: one write, one two-port read, one issue per cycle, no stalls internal to the block.

## Configuration

- REGFILE_BYPASS_EN defined: read of address X in the same cycle as write to X (X≠0) returns wr_data on that port next cycle (write-through forwarding); also applies when both ports read X.
- REGFILE_BYPASS_EN undefined: same-cycle read returns the old stored value; new value readable from the following cycle. All other behaviour identical.

## Test plan

- Reset: preload R3=0x1234, assert rst one cycle, read R3/R5 → ra_data=0x0000, rb_data=0x0000, pend_any=0, rd_valid=1 only after read.
- Write/read: write R5=0xBEEF, next cycle read ra=R5, rb=R0 → one cycle later ra_data=0xBEEF, rb_data=0x0000, rd_valid=1.
- R0 guard: write R0=0xFFFF and iss_addr=0 → read R0 returns 0x0000, pend_any stays 0.
- Bypass: R2=0x0001 stored; same cycle write R2=0x00A5 and read ra=R2 → ra_data=0x00A5 with REGFILE_BYPASS_EN, 0x0001 without.
- Scoreboard: iss R4 → ra_pend(R4)=1 next cycle; write R4 → ra_pend=0 next cycle; iss and write R4 same cycle → pend stays 1, R4 data updated.
- Hold: read R1=0x0C0C, then rd_en=0 for 3 cycles while writing R1=0x1111 → ra_data stays 0x0C0C, rd_valid=0.
